data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Load/store controller between a RISC-V style requester and a byte-lane data memory.
// Handles B/H/W sizing, lane steering, sign/zero extension and alignment/range faults.
module data_mem_ctrl #(
   parameter int unsigned MEM_BYTES = 65536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wr,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   logic [1:0]  state;
   logic [1:0]  nextState;
   logic        accept;
   logic        reqFault;
   logic [31:0] laneData;

   logic        weReg;
   logic [2:0]  funct3Reg;
   logic [1:0]  offReg;

   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [31:0] rspRdata;
   logic        rspFault;

   logic [3:0]  storeMask;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadData;

   assign req_ready = (state == IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   // NOTE: every variable driven in always_comb gets a default first so no path infers a latch.
   always_comb begin
      reqFault = 1'b0;
      case (req_funct3)
         F3_B:    reqFault = 1'b0;
         F3_BU:   reqFault = req_we;
         F3_H:    reqFault = req_addr[0];
         F3_HU:   reqFault = req_we | req_addr[0];
         F3_W:    reqFault = |req_addr[1:0];
         default: reqFault = 1'b1;
      endcase
      if ({1'b0, req_addr} >= MEM_LIMIT) begin
         reqFault = 1'b1;
      end
   end

   // Store data is replicated across lanes so the write mask alone selects the target bytes.
   always_comb begin
      laneData = req_wdata;
      case (req_funct3[1:0])
         2'b00:   laneData = {4{req_wdata[7:0]}};
         2'b01:   laneData = {2{req_wdata[15:0]}};
         default: laneData = req_wdata;
      endcase
   end

   always_comb begin
      storeMask = 4'b1111;
      case (funct3Reg[1:0])
         2'b00:   storeMask = 4'b0001 << offReg;
         2'b01:   storeMask = 4'b0011 << offReg;
         default: storeMask = 4'b1111;
      endcase
   end

   // Reset gates the enables combinationally so a store caught in ACCESS never reaches memory.
   assign mem_wr = (state == ACCESS && weReg && !reset) ? storeMask : 4'b0000;

   always_comb begin
      loadByte = mem_rdata[{offReg, 3'b000} +: 8];
      loadHalf = mem_rdata[{offReg[1], 4'b0000} +: 16];
      loadData = mem_rdata;
      case (funct3Reg)
         F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
         F3_BU:   loadData = {24'd0, loadByte};
         F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
         F3_HU:   loadData = {16'd0, loadHalf};
         default: loadData = mem_rdata;
      endcase
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = reqFault ? RESP : ACCESS;
         ACCESS:  nextState = weReg ? RESP : WAIT;
         WAIT:    nextState = RESP;
         RESP:    if (rsp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rspRdata <= 32'd0;
         rspFault <= 1'b0;
         memAddr  <= 32'd0;
         memWdata <= 32'd0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (accept) begin
                  rspFault <= reqFault;
                  rspRdata <= 32'd0;
                  if (!reqFault) begin
                     memAddr <= {req_addr[31:2], 2'b00};
                     if (req_we) memWdata <= laneData;
                  end
               end
            end
            WAIT:    rspRdata <= loadData;
            default: ;
         endcase
      end
   end

   // NOTE: request fields carry no reset; they are only consumed after an acceptance loads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         weReg     <= req_we;
         funct3Reg <= req_funct3;
         offReg    <= req_addr[1:0];
      end
   end

   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rspRdata;
   assign rsp_fault = rspFault;
   assign mem_raddr = memAddr;
   assign mem_waddr = memAddr;
   assign mem_wdata = memWdata;

   writeOnlyInAccess: assert property (@(posedge clk) disable iff (reset)
      (mem_wr != 4'b0000) |-> (state == ACCESS && weReg));

   rspHeldUntilTaken: assert property (@(posedge clk) disable iff (reset)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_fault)));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a driver queues expected responses and writes,
// a negedge monitor pops and compares them against what the controller presents.
module tb_data_mem_ctrl;

   typedef struct {
      logic        fault;
      logic [31:0] rdata;
      int          lat;
      int          acceptCycle;
   } rspExp_t;

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] data;
   } wrExp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wr;
   logic [31:0] mem_rdata;

   logic [31:0] memModel [0:16383];

   rspExp_t rspQ[$];
   wrExp_t  wrQ[$];

   int nCompared   = 0;
   int nMismatched = 0;
   int cycleCnt    = 0;

   bit chain      = 1'b0;
   int lastAccept = 0;
   int lastLat    = 0;

   bit          inResp     = 1'b0;
   bit          expectIdle = 1'b0;
   bit          haveCur    = 1'b0;
   rspExp_t     cur;
   logic [31:0] firstRdata;
   logic        firstFault;

   data_mem_ctrl #(.MEM_BYTES(65536)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .mem_raddr  (mem_raddr),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wr     (mem_wr),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Byte-lane memory with one cycle of read latency.
   initial begin
      for (int i = 0; i < 16384; i++) memModel[i] = 32'd0;
   end

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (mem_wr[k]) memModel[mem_waddr[15:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
      mem_rdata <= memModel[mem_raddr[15:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mem_wr != 4'b0000) begin
         if (wrQ.size() == 0) begin
            check("unexpected_write", {28'd0, mem_wr}, 32'd0);
         end else begin
            wrExp_t w;
            w = wrQ.pop_front();
            check("wr_mask",  {28'd0, mem_wr}, {28'd0, w.mask});
            check("wr_waddr", mem_waddr, w.addr);
            check("wr_raddr", mem_raddr, w.addr);
            check("wr_wdata", mem_wdata, w.data);
         end
      end
      if (reset) begin
         inResp     = 1'b0;
         expectIdle = 1'b0;
         haveCur    = 1'b0;
      end else begin
         if (expectIdle) begin
            check("idle_req_ready", {31'd0, req_ready}, 32'd1);
            check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            expectIdle = 1'b0;
         end
         if (rsp_valid) begin
            if (!inResp) begin
               inResp     = 1'b1;
               firstRdata = rsp_rdata;
               firstFault = rsp_fault;
               if (rspQ.size() == 0) begin
                  haveCur = 1'b0;
                  check("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  haveCur = 1'b1;
                  cur = rspQ[0];
                  check("rsp_latency", cycleCnt - cur.acceptCycle, cur.lat);
               end
            end else begin
               check("rsp_rdata_stable", rsp_rdata, firstRdata);
               check("rsp_fault_stable", {31'd0, rsp_fault}, {31'd0, firstFault});
            end
            check("rsp_req_ready_low", {31'd0, req_ready}, 32'd0);
            if (rsp_ready) begin
               if (haveCur) begin
                  void'(rspQ.pop_front());
                  check("rsp_fault", {31'd0, rsp_fault}, {31'd0, cur.fault});
                  check("rsp_rdata", rsp_rdata, cur.rdata);
               end
               inResp     = 1'b0;
               haveCur    = 1'b0;
               expectIdle = 1'b1;
            end
         end
      end
   end

   task automatic issueReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic expFault,
                           input logic [31:0] expRdata, input logic [3:0] expMask,
                           input logic [31:0] expLane, input logic drop);
      rspExp_t r;
      wrExp_t  w;
      int      lat;
      bit      ok;
      lat = expFault ? 1 : (we ? 2 : 3);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         chain     = 1'b0;
         return;
      end
      if (chain) check("throughput", cycleCnt - lastAccept, lastLat + 1);
      lastAccept = cycleCnt;
      lastLat    = lat;
      chain      = 1'b1;
      if (!drop) begin
         r.fault = expFault;
         r.rdata = expRdata;
         r.lat   = lat;
         r.acceptCycle = cycleCnt;
         rspQ.push_back(r);
         if (we && !expFault) begin
            w.mask = expMask;
            w.addr = {addr[31:2], 2'b00};
            w.data = expLane;
            wrQ.push_back(w);
         end
      end
      @(posedge clk);
      #1;
      // Scramble the request fields: the controller must work from what it latched.
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = ~addr;
      req_wdata  = ~wdata;
   endtask

   task automatic doStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] lane);
      issueReq(1'b1, f3, addr, wdata, 1'b0, 32'd0, mask, lane, 1'b0);
   endtask

   task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
      issueReq(1'b0, f3, addr, 32'h5A5A5A5A, 1'b0, exp, 4'b0000, 32'd0, 1'b0);
   endtask

   task automatic doFault(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
      issueReq(we, f3, addr, wdata, 1'b1, 32'd0, 4'b0000, 32'd0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (rspQ.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain_rsp_queue", rspQ.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      rsp_ready  = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_mem_wr",    {28'd0, mem_wr}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_raddr", mem_raddr, 32'd0);
      check("rst_mem_waddr", mem_waddr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

      // Word, byte and halfword traffic around 0x100.
      doStore(3'b010, 32'h100, 32'hA1B2C3D4, 4'b1111, 32'hA1B2C3D4);
      doLoad (3'b010, 32'h100, 32'hA1B2C3D4);
      doStore(3'b000, 32'h103, 32'h000000F0, 4'b1000, 32'hF0F0F0F0);
      doLoad (3'b000, 32'h103, 32'hFFFFFFF0);
      doLoad (3'b100, 32'h103, 32'h000000F0);
      doLoad (3'b010, 32'h100, 32'hF0B2C3D4);
      doLoad (3'b000, 32'h101, 32'hFFFFFFC3);
      doStore(3'b001, 32'h102, 32'h00008001, 4'b1100, 32'h80018001);
      doLoad (3'b001, 32'h102, 32'hFFFF8001);
      doLoad (3'b101, 32'h102, 32'h00008001);
      doLoad (3'b001, 32'h100, 32'hFFFFC3D4);
      doLoad (3'b010, 32'h100, 32'h8001C3D4);

      // Low lanes, with junk in the unused upper store bits.
      doStore(3'b001, 32'h200, 32'hDEAD1234, 4'b0011, 32'h12341234);
      doStore(3'b000, 32'h201, 32'h1234567F, 4'b0010, 32'h7F7F7F7F);
      doLoad (3'b010, 32'h200, 32'h00007F34);
      doLoad (3'b100, 32'h200, 32'h00000034);
      doLoad (3'b000, 32'h201, 32'h0000007F);

      // Last word of memory.
      doStore(3'b010, 32'hFFFC, 32'h55AA55AA, 4'b1111, 32'h55AA55AA);
      doLoad (3'b010, 32'hFFFC, 32'h55AA55AA);
      doLoad (3'b101, 32'hFFFE, 32'h000055AA);
      doLoad (3'b000, 32'hFFFC, 32'hFFFFFFAA);

      // Faults: misalignment, illegal sizes, out of range.
      doFault(1'b0, 3'b010, 32'h101,   32'd0);
      doFault(1'b1, 3'b001, 32'h001,   32'h1111);
      doFault(1'b1, 3'b100, 32'h100,   32'hFFFFFFFF);
      doFault(1'b0, 3'b011, 32'h100,   32'd0);
      doFault(1'b0, 3'b010, 32'h10000, 32'd0);
      doFault(1'b1, 3'b010, 32'h102,   32'h0BADF00D);
      doFault(1'b0, 3'b101, 32'h103,   32'd0);
      doFault(1'b0, 3'b111, 32'h100,   32'd0);
      doFault(1'b1, 3'b000, 32'h10000, 32'h000000EE);
      doLoad (3'b010, 32'h100, 32'h8001C3D4);

      // Response held off for five cycles.
      drain();
      rsp_ready = 1'b0;
      chain     = 1'b0;
      doLoad(3'b010, 32'h200, 32'h00007F34);
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) break;
         @(posedge clk);
         #1;
      end
      check("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("stall_still_valid", {31'd0, rsp_valid}, 32'd1);
      rsp_ready = 1'b1;
      chain     = 1'b0;

      // Reset lands in a store's ACCESS cycle.
      drain();
      chain = 1'b0;
      issueReq(1'b1, 3'b010, 32'h300, 32'hFFFFFFFF, 1'b0, 32'd0, 4'b1111, 32'hFFFFFFFF, 1'b1);
      check("pre_reset_mem_wr", {28'd0, mem_wr}, 32'h0000000F);
      reset = 1'b1;
      #1;
      check("mid_reset_mem_wr",    {28'd0, mem_wr}, 32'd0);
      check("mid_reset_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("after_reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("after_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chain = 1'b0;
      doLoad(3'b010, 32'h300, 32'h00000000);

      drain();
      repeat (3) @(posedge clk);
      #1;
      check("write_queue_empty", wrQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
